// File: rtl/bsg_mask_merge_accum.sv
// bsg_mask_merge_accum: merges masked write beats into one word and emits it on a valid/yumi handshake
module bsg_mask_merge_accum #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic [width_p-1:0] mask_i,
  input  logic               last_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic [width_p-1:0] mask_o,
  input  logic               yumi_i
);
  typedef enum logic {ACCUM, OUT} state_e;
  state_e state_r, state_n;
  logic [width_p-1:0] data_r, cov_r, data_n, cov_n, base, cov_base, merged, new_cov;
  logic take, pop, done;
  assign v_o      = state_r == OUT;
  assign ready_o  = v_o ? yumi_i : 1'b1;
  assign pop      = v_o & yumi_i;
  assign take     = v_i & ready_o;
  assign base     = v_o ? '0 : data_r;
  assign cov_base = v_o ? '0 : cov_r;
  assign merged   = (data_i & mask_i) | (base & ~mask_i);
  assign new_cov  = cov_base | mask_i;
  assign done     = (&new_cov) | last_i;
  assign data_o   = data_r;
  assign mask_o   = cov_r;
  // next state: a pop clears the word unless a same-cycle beat starts the next one
  always_comb begin
    state_n = take ? (done ? OUT : ACCUM) : (pop ? ACCUM : state_r);
    data_n  = take ? merged : (pop ? '0 : data_r);
    cov_n   = take ? new_cov : (pop ? '0 : cov_r);
  end
  // state, held word and coverage registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= ACCUM;
      data_r  <= '0;
      cov_r   <= '0;
    end else begin
      state_r <= state_n;
      data_r  <= data_n;
      cov_r   <= cov_n;
    end
  end
endmodule

// File: doc/bsg_mask_merge_accum.md
# bsg_mask_merge_accum

Accumulating front-end for the per-bit select mux. It collects a sequence of partially-masked write beats into one holding word, merging each beat bit by bit: a bit takes the new data where the beat's mask is 1 and keeps the held value where it is 0. It tracks which bits have been written so far. It emits the merged word and its coverage mask on a valid/yumi handshake when the word is fully covered or the producer marks the last beat. The per-bit merge of each beat is exactly the data0/data1/sel bitwise mux function, with held word, new data and mask as the three inputs.

## Interface
- width_p, 16, word width in bits; also the width of the mask and the coverage mask.
- clk_i  in  1  clock; all state is updated on its rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- v_i  in  1  input beat valid.
- data_i  in  width_p  beat data.
- mask_i  in  width_p  per-bit write enable; 1 means take data_i for that bit.
- last_i  in  1  force emit after this beat.
- ready_o  out  1  beat is accepted in any cycle where v_i & ready_o.
- v_o  out  1  merged word valid.
- data_o  out  width_p  merged word.
- mask_o  out  width_p  coverage mask, i.e. the OR of all accepted masks.
- yumi_i  in  1  consumer takes the word; legal only when v_o=1.

## Operation
- State registers:
  - state_r, one of ACCUM or OUT.
  - data_r[width_p].
  - cov_r[width_p].
- Reset is asynchronous and takes effect immediately: state_r=ACCUM, data_r=0, cov_r=0. Outputs then read v_o=0, ready_o=1, data_o=0, mask_o=0.
- Merge rule for each accepted beat:
  - merged = (data_i & mask_i) | (base & ~mask_i).
  - new_cov = cov_base | mask_i.
  - In ACCUM: base=data_r and cov_base=cov_r.
  - In OUT with a same-cycle pop: base=0 and cov_base=0, so the next word starts fresh.
- ACCUM state:
  - v_o=0, ready_o=1.
  - On acceptance: data_r<=merged and cov_r<=new_cov.
  - If new_cov is all ones or last_i=1, go to OUT; otherwise stay in ACCUM.
- OUT state:
  - v_o=1; data_o=data_r and mask_o=cov_r, held stable until popped.
  - ready_o=yumi_i, so a new beat is accepted only in the same cycle as the pop.
  - yumi_i without an accepted beat: data_r<=0, cov_r<=0, go to ACCUM.
  - yumi_i with an accepted beat: load merged/new_cov from the zero base. Stay in OUT if the new coverage is full or last_i=1; otherwise go to ACCUM.
  - No yumi_i: hold all state; any v_i is ignored (not accepted).
- Overlapping masks: the later beat wins on bits set in both masks.
- A beat with mask_i=0 and last_i=0 is accepted and changes nothing.
- A beat with mask_i=0 and last_i=1 emits the current contents. If nothing was accumulated, the emitted word has data_o=0 and mask_o=0.
- yumi_i while v_o=0 is illegal; the design ignores it and the testbench flags it.

## Timing
- Latency: a beat that completes a word, accepted at edge N, makes v_o=1 after edge N, i.e. in cycle N+1.
- Throughput:
  - One fully-masked beat per cycle, back to back, when yumi_i is held high; ready_o stays 1.
  - With a single beat per word, each word spends one cycle in OUT.
- v_o, data_o and mask_o are driven directly from registers; there is no combinational path from the inputs.
- ready_o depends combinationally on yumi_i while in OUT. yumi_i must not depend combinationally on ready_o.
- Reset asserted mid-word or in OUT discards the held word at once. After reset deasserts, the first accepted beat starts a fresh word.

## Test plan
- Two halves: beat mask=0x00FF data=0x1234, then beat mask=0xFF00 data=0xAB00.
  - Required: v_o rises one cycle after the second beat, with data_o=0xAB34 and mask_o=0xFFFF.
- Overlap: mask=0x0FF0 data=0x0AA0, then mask=0x00F0 data=0x0050 with last_i=1.
  - Required: data_o=0x0A50 and mask_o=0x0FF0.
- Backpressure and bypass: word 0xFFFF/0xFFFF is emitted. Hold yumi_i=0 for 3 cycles while v_i=1 with mask=0xFFFF data=0x5555, then pulse yumi_i.
  - Required: ready_o=0 and data_o=0xFFFF stay stable during the stall.
  - Required: 0x5555 is accepted in the pop cycle and appears on data_o in the next cycle, with v_o still 1.
- Empty flush: from reset, beat mask=0 last_i=1.
  - Required: v_o=1 with data_o=0 and mask_o=0; after the pop, state returns to ACCUM.
- Mid-word reset: accept mask=0x000F data=0x0003, then assert reset_i asynchronously between edges.
  - Required: outputs are zero immediately.
  - Required: after release, mask=0xFFF0 data=0x1110 with last_i=1 gives data_o=0x1110 and mask_o=0xFFF0.
- Random soak: constrained-random v_i, mask_i, last_i and yumi_i, checked against a reference model of the merge rule for 10k cycles.
  - Required: no mismatch, and no output change while v_o=1 and yumi_i=0.
